// File: rtl/pwm_led_pkg.sv
// Shared constants and types for the four-channel PWM LED controller.
package pwm_led_pkg;

  localparam int NUM_CH   = 4;
  localparam int DUTY_W   = 8;

  // Bit positions inside uio_in / uio_out.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int WR_BIT   = 2;
  localparam int BR_BIT   = 3;
  localparam int PS_BIT   = 4;

  // Upper nibble of uio drives outputs, lower nibble stays input.
  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  // Direction of the shared breathe ramp.
  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;

endpackage : pwm_led_pkg

// File: rtl/pwm_led_channel.sv
// One PWM channel: double-buffered duty, breathe select and compare.
module pwm_led_channel
  import pwm_led_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DUTY_W-1:0] wr_duty_i,
  input  logic              wr_breathe_i,
  input  logic              ps_i,
  input  logic [DUTY_W-1:0] ramp_i,
  input  logic [DUTY_W-1:0] cnt_i,
  output logic              pwm_o
);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              breathe_q, breathe_d;
  logic [DUTY_W-1:0] eff_duty;

  // Next-state for the write-side shadow and the period-aligned active copy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    shadow_d  = shadow_q;
    breathe_d = breathe_q;
    active_d  = active_q;
    if (wr_en_i) begin
      shadow_d  = wr_duty_i;
      breathe_d = wr_breathe_i;
    end
    // Reload samples the old shadow, so a write on the same edge waits a period.
    if (ps_i) begin
      active_d = shadow_q;
    end
  end

  // Duty state registers; reset is synchronous and active-high on rst_n.
  always_ff @(posedge clk) begin
    // NOTE: the duty registers are a handful of flops, not a RAM, so they are reset explicitly to give a known dark start.
    if (rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      breathe_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      breathe_q <= breathe_d;
    end
  end

  assign eff_duty = breathe_q ? ramp_i : active_q;
  assign pwm_o    = (cnt_i < eff_duty);

endmodule : pwm_led_channel

// File: rtl/tt_um_pwm_led_top.sv
// Tiny Tapeout wrapper: prescaler, period counter, breathe ramp,
// write decode and registered outputs around four PWM channels.
module tt_um_pwm_led_top
  import pwm_led_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0]       presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] ramp_q, ramp_d;
  ramp_dir_e         dir_q, dir_d;
  logic [7:0]        uo_q, uo_d;
  logic              ps_q, ps_d;

  logic              tick;
  logic              ps;
  logic [NUM_CH-1:0] pwm;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_stb;
  logic              unused_ok;

  assign tick    = ena && (presc_q == PRESC_MAX);
  assign ps      = tick && (cnt_q == '1);
  assign wr_addr = uio_in[ADDR_LSB +: ADDR_W];
  assign wr_stb  = ena && uio_in[WR_BIT];

  // Upper control bits carry no function.
  assign unused_ok = ^uio_in[7:4];

  // Timebase, ramp and output next-state; everything holds while ena is low.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    ramp_d  = ramp_q;
    dir_d   = dir_q;
    uo_d    = 8'h00;
    ps_d    = 1'b0;
    if (ena) begin
      presc_d = (presc_q == PRESC_MAX) ? 16'd0 : presc_q + 16'd1;
      uo_d    = {~pwm, pwm};
      ps_d    = ps;
    end
    if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Triangle ramp flips direction on the step that lands on an end value.
    if (ps) begin
      if (dir_q == RAMP_UP) begin
        ramp_d = ramp_q + 1'b1;
        if (ramp_q == 8'hFE) dir_d = RAMP_DOWN;
      end else begin
        ramp_d = ramp_q - 1'b1;
        if (ramp_q == 8'h01) dir_d = RAMP_UP;
      end
    end
  end

  // Timebase and output registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ramp_q  <= '0;
      dir_q   <= RAMP_UP;
      uo_q    <= 8'h00;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      dir_q   <= dir_d;
      uo_q    <= uo_d;
      ps_q    <= ps_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_led_channel u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (wr_stb && (wr_addr == ADDR_W'(i))),
      .wr_duty_i    (ui_in),
      .wr_breathe_i (uio_in[BR_BIT]),
      .ps_i         (ps),
      .ramp_i       (ramp_q),
      .cnt_i        (cnt_q),
      .pwm_o        (pwm[i])
    );
  end

  assign uo_out  = uo_q;
  assign uio_out = {{(7 - PS_BIT){1'b0}}, ps_q, {PS_BIT{1'b0}}};
  assign uio_oe  = UIO_OE_VAL;

endmodule : tt_um_pwm_led_top

// File: tb/tb_tt_um_pwm_led_top.sv
// Directed bench for tt_um_pwm_led_top. dut4 (PRESCALE=4) covers most
// features; dut1 (PRESCALE=1) shares the stimulus and is watched only for
// the full breathe ramp so that run stays short.
module tb_tt_um_pwm_led_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo4, uio4, oe4;
  logic [7:0] uo1, uio1, oe1;

  int  errors = 0;
  int  checks = 0;
  int  hi[8];
  int  ps_n;
  bit  ps_last;
  int  rise0;
  bit  sel = 1'b0;

  logic [7:0] obs_uo, obs_uio;
  assign obs_uo  = sel ? uo1 : uo4;
  assign obs_uio = sel ? uio1 : uio4;

  always #5 clk = ~clk;

  tt_um_pwm_led_top #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
  );

  tt_um_pwm_led_top #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
  );

  // One-clock write strobe.
  task automatic write_ch(input logic [7:0] d, input logic [7:0] c);
    @(negedge clk);
    ui_in  = d;
    uio_in = c;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  // Advance to the sample that shows the period-start pulse (bounded).
  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!obs_uio[4] && n < 3000);
    checks++;
    if (!obs_uio[4]) begin
      errors++;
      $display("FAIL wait_ps: no period-start pulse after %0d clocks", n);
    end
  endtask

  // Sample one period starting at a pulse sample; optional write at sample wr_at.
  task automatic measure(input int plen, input int wr_at,
                         input logic [7:0] wr_d, input logic [7:0] wr_c);
    logic prev0;
    for (int b = 0; b < 8; b++) hi[b] = 0;
    ps_n = 0; rise0 = 0; ps_last = 1'b0;
    prev0 = obs_uo[0];
    for (int i = 1; i <= plen; i++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) hi[b] += int'(obs_uo[b]);
      if (obs_uo[0] && !prev0) rise0++;
      prev0 = obs_uo[0];
      if (obs_uio[4]) ps_n++;
      if (i == plen) ps_last = obs_uio[4];
      if (i == wr_at + 1) uio_in = 8'h00;
      if (i == wr_at) begin
        ui_in  = wr_d;
        uio_in = wr_c;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'h04;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (uo4 !== 8'h00 || uio4 !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: uo_out=%h uio_out=%h, need 00/00", uo4, uio4);
      end
    end
    checks++;
    if (oe4 !== 8'hF0) begin
      errors++;
      $display("FAIL reset_uio_oe: got %h need F0", oe4);
    end
    rst_n = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (uo4 !== 8'hF0) begin
          errors++;
          $display("FAIL release_uo: got %h need F0", uo4);
        end
      end
    end while (!uio4[4] && n < 2000);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL first_ps: pulse after %0d clocks, need 1024", n);
    end
    measure(1024, -1, 8'h00, 8'h00);
    checks++;
    if (hi[0] !== 0) begin
      errors++;
      $display("FAIL reset_beats_write: ch0 high %0d clocks, need 0", hi[0]);
    end
    checks++;
    if (oe4 !== 8'hF0) begin
      errors++;
      $display("FAIL run_uio_oe: got %h need F0", oe4);
    end
  endtask

  task automatic test_basic_duty();
    write_ch(8'd64, 8'h04);
    wait_ps();
    measure(1024, -1, 8'h00, 8'h00);
    checks++;
    if (hi[0] !== 256 || rise0 !== 1) begin
      errors++;
      $display("FAIL basic_ch0: high=%0d runs=%0d, need 256/1", hi[0], rise0);
    end
    checks++;
    if (hi[4] !== 768) begin
      errors++;
      $display("FAIL basic_ch0_inv: high=%0d need 768", hi[4]);
    end
    checks++;
    if (hi[1] + hi[2] + hi[3] !== 0 || hi[5] + hi[6] + hi[7] !== 3072) begin
      errors++;
      $display("FAIL basic_others: ch1..3 high=%0d inv high=%0d, need 0/3072",
               hi[1] + hi[2] + hi[3], hi[5] + hi[6] + hi[7]);
    end
    checks++;
    if (ps_n !== 1 || !ps_last) begin
      errors++;
      $display("FAIL basic_period: pulses=%0d at_end=%0d, need 1/1", ps_n, ps_last);
    end
  endtask

  task automatic test_bounds();
    write_ch(8'd0, 8'h06);
    write_ch(8'd255, 8'h07);
    wait_ps();
    measure(1024, -1, 8'h00, 8'h00);
    checks++;
    if (hi[2] !== 0) begin
      errors++;
      $display("FAIL bound_zero: ch2 high=%0d need 0", hi[2]);
    end
    checks++;
    if (hi[3] !== 1020 || hi[7] !== 4) begin
      errors++;
      $display("FAIL bound_full: ch3 high=%0d inv=%0d, need 1020/4", hi[3], hi[7]);
    end
    checks++;
    if (hi[0] !== 256) begin
      errors++;
      $display("FAIL bound_ch0_kept: high=%0d need 256", hi[0]);
    end
  endtask

  task automatic test_mid_period();
    int exp_hi[5];
    exp_hi = '{128, 512, 512, 512, 64};
    write_ch(8'd32, 8'h04);
    wait_ps();
    for (int p = 0; p < 5; p++) begin
      if (p == 0)      measure(1024, 400, 8'd128, 8'h04);
      else if (p == 2) measure(1024, 1023, 8'd16, 8'h04);
      else             measure(1024, -1, 8'h00, 8'h00);
      checks++;
      if (hi[0] !== exp_hi[p] || !ps_last) begin
        errors++;
        $display("FAIL mid_write_p%0d: ch0 high=%0d ps_end=%0d, need %0d/1",
                 p, hi[0], ps_last, exp_hi[p]);
      end
    end
  endtask

  task automatic test_enable();
    int en_cnt, frz, total, bad, h0, h3, pulses;
    bit ps_end;
    write_ch(8'd64, 8'h04);
    wait_ps();
    en_cnt = 0; frz = 0; total = 0; bad = 0; h0 = 0; h3 = 0; pulses = 0; ps_end = 1'b0;
    while (en_cnt < 1024 && total < 3000) begin
      @(negedge clk);
      total++;
      if (ena) begin
        en_cnt++;
        h0 += int'(uo4[0]);
        h3 += int'(uo4[3]);
        if (uio4[4]) pulses++;
        if (en_cnt == 1024) ps_end = uio4[4];
      end else begin
        frz++;
        if (uo4 !== 8'h00 || uio4 !== 8'h00) bad++;
      end
      if (ena && en_cnt == 100) ena = 1'b0;
      else if (!ena && frz == 500) ena = 1'b1;
    end
    ena = 1'b1;
    checks++;
    if (bad !== 0 || frz !== 500) begin
      errors++;
      $display("FAIL enable_blank: nonzero samples=%0d frozen=%0d, need 0/500", bad, frz);
    end
    checks++;
    if (h0 !== 256 || h3 !== 1020) begin
      errors++;
      $display("FAIL enable_resume: ch0=%0d ch3=%0d, need 256/1020", h0, h3);
    end
    checks++;
    if (pulses !== 1 || !ps_end || total !== 1524) begin
      errors++;
      $display("FAIL enable_period: pulses=%0d at_end=%0d total=%0d, need 1/1/1524",
               pulses, ps_end, total);
    end
  endtask

  task automatic test_breathe();
    int exp_r;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    write_ch(8'd200, 8'h0D);
    write_ch(8'd64, 8'h04);
    sel = 1'b1;
    wait_ps();
    for (int k = 1; k <= 257; k++) begin
      exp_r = (k <= 255) ? k : 510 - k;
      measure(256, -1, 8'h00, 8'h00);
      checks++;
      if (hi[1] !== exp_r || hi[0] !== 64 || !ps_last) begin
        errors++;
        $display("FAIL breathe_k%0d: ch1=%0d ch0=%0d ps_end=%0d, need %0d/64/1",
                 k, hi[1], hi[0], ps_last, exp_r);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_bounds();
    test_mid_period();
    test_enable();
    test_breathe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tt_um_pwm_led_top

// File: doc/tt_um_pwm_led_top.md
Name: tt_um_pwm_led_top

Overview:
- Four-channel 8-bit PWM LED controller in the Tiny Tapeout harness wrapper.
- One shared prescaler and 8-bit period counter drive four channels. Each channel has a double-buffered duty register and an optional "breathe" mode that follows a shared triangle ramp.
- Channels are written through ui_in/uio_in. PWM drives uo_out, in both active-high and active-low copies.

Parameters:
- PRESCALE, default 4: clocks per PWM counter tick, legal 1..65535. PWM period = 256*PRESCALE clocks.

Ports:
- clk  input  1  single system clock.
- rst_n  input  1  reset, synchronous and active-high: rst_n=1 at a clk edge resets. The port name follows the harness convention; polarity is active-high regardless of the suffix.
- ena  input  1  design enable; low freezes all counters and blanks outputs.
- ui_in  input  8  write data: duty value, 0..255.
- uio_in  input  8  control inputs:
  - [1:0] channel address.
  - [2] write strobe, level-sensitive.
  - [3] breathe bit written along with the duty.
  - [7:4] ignored.
- uo_out  output  8  [3:0] PWM for channels 0..3, active-high; [7:4] bitwise inverse of [3:0] for active-low LEDs.
- uio_out  output  8  [4] period-start pulse; all other bits 0.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - prescaler=0, cnt=0, ramp=0, ramp direction=up.
  - All shadow duty, active duty and breathe bits = 0.
  - uo_out=8'h00, uio_out=8'h00.
  - Reset wins over ena and write.
- Prescaler (only when ena=1): counts 0..PRESCALE-1. Its wrap produces a one-clock tick.
- Period counter cnt[7:0]: increments on each tick and wraps 255->0. The tick on which cnt goes 255->0 is the period start (ps).
- Write: when ena=1 and uio_in[2]=1, at the clk edge:
  - shadow_duty[addr] <= ui_in.
  - breathe[addr] <= uio_in[3].
  - Writes repeat every cycle while the strobe is held; the last value wins.
- Active duty reload: at ps, active_duty[i] <= shadow_duty[i] for every channel.
  - A mid-period write never changes the current period.
  - A write on the same edge as ps is not captured into active duty until the next ps.
- Breathe ramp (8-bit), advanced at ps:
  - Going up: +1; on reaching 255 the direction flips to down.
  - Going down: -1; on reaching 0 the direction flips to up.
  - Sequence: 0,1,..,255,254,..,0,1,...
- Effective duty: eff[i] = breathe[i] ? ramp : active_duty[i].
- Compare: pwm[i] = (cnt < eff[i]), unsigned.
  - duty 0 -> always low.
  - duty 255 -> high 255 of 256 ticks.
- Output registers:
  - uo_out[3:0] <= pwm, uo_out[7:4] <= ~pwm, one clock after the compare.
  - uio_out[4] <= ps: a one-clock pulse once per period.
- ena=0:
  - Prescaler, cnt, ramp and all registers hold; writes are ignored.
  - uo_out <= 8'h00, uio_out <= 8'h00.
  - On ena=1 the count resumes from the held values.
- uio_oe is constant 8'hF0 at all times, including during reset.

Decomposition:
- Package pwm_led_pkg:
  - NUM_CH=4, DUTY_W=8.
  - Address/strobe/breathe bit-index constants: ADDR_LSB=0, WR_BIT=2, BR_BIT=3, PS_BIT=4.
- Sub-module pwm_led_channel, instantiated NUM_CH times. It contains the shadow and active duty registers, the breathe bit, the effective-duty mux and the compare.
- The top level holds the prescaler, cnt, ramp, write decode and output registers.

Test Plan:
- Reset: hold rst_n=1 for 3 clocks with ena=1 -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'hF0. One clock after release -> uo_out=8'hF0, and uio_out[4] first pulses 1024 clocks later.
- Basic duty: write ch0=64 (ui_in=64, uio_in=8'h04 for 1 clock). Starting after the next ps, each 1024-clock period -> uo_out[0] high for exactly 256 consecutive clocks and uo_out[4] the inverse; ch1..3 stay low.
- Bounds: ch2=0 -> uo_out[2] never high. ch3=255 -> uo_out[3] high for 1020 of every 1024 clocks.
- Mid-period write:
  - With ch0 active=32, write 128 at cnt=100 -> the current period is still 128 clocks high, the next period 512.
  - A write on the ps edge takes effect one period later.
- Breathe: write ch1 with uio_in=8'h0D -> high time is 0,4,8,.. clocks in successive periods, peaks at 1020 at ramp=255, then decreases by 4 per period. Ch0 is unaffected.
- Enable: drop ena for 500 clocks mid-period -> uo_out=8'h00 and no ps pulse during that time. After re-enable, high time completes from the held cnt; the total period length equals 1024 enabled clocks.
